// File: rtl/voice_pkg.sv
// Shared types and constants for the voice allocator slice.
package voice_pkg;
  localparam int NOTE_W = 8;
  localparam logic [NOTE_W-1:0] NOTE_SILENT = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_WRITE = 2'd2
  } state_t;
endpackage

// File: rtl/voice_select.sv
// Combinational voice search: note hit, lowest free voice, oldest active voice.
module voice_select
  import voice_pkg::*;
#(
  parameter int NVOICES = 4,
  parameter int AGE_W   = 4,
  localparam int IDX_W  = (NVOICES > 1) ? $clog2(NVOICES) : 1
) (
  input  logic [NVOICES-1:0][NOTE_W-1:0] iNotes,
  input  logic [NVOICES-1:0]             iActive,
  input  logic [NVOICES-1:0][AGE_W-1:0]  iAges,
  input  logic [NOTE_W-1:0]              iNote,
  output logic                           oHit,
  output logic [IDX_W-1:0]               oHitIdx,
  output logic                           oFree,
  output logic [IDX_W-1:0]               oFreeIdx,
  output logic [IDX_W-1:0]               oOldIdx
);
  logic             w_found;
  logic [AGE_W-1:0] w_maxAge;

  always_comb begin
    oHit     = 1'b0;
    oHitIdx  = '0;
    oFree    = 1'b0;
    oFreeIdx = '0;
    oOldIdx  = '0;
    w_found  = 1'b0;
    w_maxAge = '0;
    // Scan downward so the lowest matching index is the one left standing.
    for (int i = NVOICES - 1; i >= 0; i--) begin
      if (iActive[i] && iNotes[i] == iNote) begin
        oHit    = 1'b1;
        oHitIdx = IDX_W'(i);
      end
      if (!iActive[i]) begin
        oFree    = 1'b1;
        oFreeIdx = IDX_W'(i);
      end
    end
    // Strict compare keeps the lowest index on equal ages.
    for (int i = 0; i < NVOICES; i++) begin
      if (iActive[i] && (!w_found || iAges[i] > w_maxAge)) begin
        w_found  = 1'b1;
        w_maxAge = iAges[i];
        oOldIdx  = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Key-event to tone-voice allocator: IDLE -> MATCH -> WRITE per event.
// Define VOICE_ALLOCATOR_STEAL_EN to steal the oldest voice when all are busy.
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NVOICES = 4,
  parameter int AGE_W   = 4
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iEvtValid,
  input  logic                      iEvtPress,
  input  logic [7:0]                iNote,
  output logic                      oEvtReady,
  input  logic                      iAllOff,
  output logic [8*NVOICES-1:0]      oVoiceNote,
  output logic [NVOICES-1:0]        oVoiceActive,
  output logic                      oDrop
);
  localparam int IDX_W = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  state_t                          r_state;
  logic [NVOICES-1:0][NOTE_W-1:0]  r_note;
  logic [NVOICES-1:0]              r_active;
  logic [NVOICES-1:0][AGE_W-1:0]   r_age;
  logic                            r_drop;
  logic                            r_evPress;
  logic [NOTE_W-1:0]               r_evNote;
  logic                            r_hit, r_free;
  logic [IDX_W-1:0]                r_hitIdx, r_freeIdx, r_oldIdx;

  logic                            w_hit, w_free;
  logic [IDX_W-1:0]                w_hitIdx, w_freeIdx, w_oldIdx;
  logic                            w_commit, w_release, w_drop;
  logic [IDX_W-1:0]                w_tgt;

  voice_select #(.NVOICES(NVOICES), .AGE_W(AGE_W)) u_sel (
    .iNotes  (r_note),
    .iActive (r_active),
    .iAges   (r_age),
    .iNote   (r_evNote),
    .oHit    (w_hit),
    .oHitIdx (w_hitIdx),
    .oFree   (w_free),
    .oFreeIdx(w_freeIdx),
    .oOldIdx (w_oldIdx)
  );

  // Target defaults to the oldest voice; hit and free voices take precedence.
  always_comb begin
    w_commit  = 1'b0;
    w_release = 1'b0;
    w_drop    = 1'b0;
    w_tgt     = r_oldIdx;
    if (r_state == ST_WRITE && r_evNote != NOTE_SILENT) begin
      if (!r_evPress) begin
        w_release = r_hit;
      end else if (r_hit) begin
        w_commit = 1'b1;
        w_tgt    = r_hitIdx;
      end else if (r_free) begin
        w_commit = 1'b1;
        w_tgt    = r_freeIdx;
      end else begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
        w_commit = 1'b1;
`else
        w_drop   = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= ST_IDLE;
      r_note    <= '0;
      r_active  <= '0;
      r_age     <= '0;
      r_drop    <= 1'b0;
      r_evPress <= 1'b0;
      r_evNote  <= NOTE_SILENT;
      r_hit     <= 1'b0;
      r_free    <= 1'b0;
      r_hitIdx  <= '0;
      r_freeIdx <= '0;
      r_oldIdx  <= '0;
    end else if (iAllOff) begin
      r_state  <= ST_IDLE;
      r_note   <= '0;
      r_active <= '0;
      r_age    <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        ST_IDLE: if (iEvtValid) begin
          r_evPress <= iEvtPress;
          r_evNote  <= iNote;
          r_state   <= ST_MATCH;
        end
        ST_MATCH: begin
          r_hit     <= w_hit;
          r_hitIdx  <= w_hitIdx;
          r_free    <= w_free;
          r_freeIdx <= w_freeIdx;
          r_oldIdx  <= w_oldIdx;
          r_state   <= ST_WRITE;
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
          r_drop  <= w_drop;
          for (int i = 0; i < NVOICES; i++) begin
            if (w_commit) begin
              if (IDX_W'(i) == w_tgt) begin
                r_note[i]   <= r_evNote;
                r_active[i] <= 1'b1;
                r_age[i]    <= '0;
              end else if (r_active[i] && r_age[i] != AGE_MAX) begin
                r_age[i] <= r_age[i] + 1'b1;
              end
            end
            if (w_release && IDX_W'(i) == r_hitIdx) begin
              r_note[i]   <= NOTE_SILENT;
              r_active[i] <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oEvtReady    = (r_state == ST_IDLE) && !iRst;
  assign oVoiceNote   = r_note;
  assign oVoiceActive = r_active;
  assign oDrop        = r_drop;
endmodule
